// File: rtl/fft_pkg.sv
// Shared constants, types and FSM encoding for the FFT peak tracker slice.
package fft_pkg;

  localparam int FFT_N  = 512;
  localparam int IDX_W  = 9;
  localparam int DATA_W = 16;

  typedef logic [2*DATA_W:0] mag_t;
  typedef logic [IDX_W-1:0]  bin_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    PUBLISH
  } peak_state_t;

endpackage

// File: rtl/mag_sq_pipe.sv
// Two-stage |X|^2 pipeline: squares re/im in stage 1, sums them in stage 2,
// carrying valid, bin index and a last-bin tag alongside the data.
module mag_sq_pipe #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [IDX_W-1:0]         in_index,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [IDX_W-1:0]         out_index,
  output logic [2*DATA_W:0]        out_sum,
  output logic                     pipe_busy
);

  logic signed [2*DATA_W-1:0] re_sq;
  logic signed [2*DATA_W-1:0] im_sq;
  logic                       in_last;

  logic                       s1_valid;
  logic                       s1_last;
  logic [IDX_W-1:0]           s1_index;
  logic [2*DATA_W-1:0]        s1_re_sq;
  logic [2*DATA_W-1:0]        s1_im_sq;

  // Sign-extend before multiplying so (-2^(W-1))^2 lands exactly in 2W bits.
  assign re_sq   = (2*DATA_W)'(in_re) * (2*DATA_W)'(in_re);
  assign im_sq   = (2*DATA_W)'(in_im) * (2*DATA_W)'(in_im);
  assign in_last = in_valid && (&in_index);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_index <= '0;
      s1_re_sq <= '0;
      s1_im_sq <= '0;
    end else begin
      s1_valid <= in_valid && !flush;
      s1_last  <= in_last && !flush;
      s1_index <= in_index;
      s1_re_sq <= re_sq;
      s1_im_sq <= im_sq;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_index <= '0;
      out_sum   <= '0;
    end else begin
      out_valid <= s1_valid && !flush;
      out_last  <= s1_last && !flush;
      out_index <= s1_index;
      out_sum   <= {1'b0, s1_re_sq} + {1'b0, s1_im_sq};
    end
  end

  assign pipe_busy = s1_valid || out_valid;

endmodule

// File: rtl/fft_peak_tracker.sv
// Tracks the largest |X|^2 bin of each FFT frame and publishes it at frame end.
// Optional macro PEAK_THRESH_EN adds a publish threshold (thresh) and peak_hit.
module fft_peak_tracker #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int IDX_W  = fft_pkg::IDX_W,
  parameter int LO_BIN = 1,
  parameter int HI_BIN = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     reset_max,
  input  logic                     bin_valid,
  input  logic [IDX_W-1:0]         bin_index,
  input  logic signed [DATA_W-1:0] bin_re,
  input  logic signed [DATA_W-1:0] bin_im,
`ifdef PEAK_THRESH_EN
  input  logic [2*DATA_W:0]        thresh,
  output logic                     peak_hit,
`endif
  output logic [IDX_W-1:0]         peak_index,
  output logic [2*DATA_W:0]        peak_mag,
  output logic                     frame_done,
  output logic                     busy
);

  import fft_pkg::*;

  localparam logic [IDX_W-1:0] LO_IDX = IDX_W'(LO_BIN);
  localparam logic [IDX_W-1:0] HI_IDX = IDX_W'(HI_BIN);

  peak_state_t         state;
  peak_state_t         next_state;

  logic                s2_valid;
  logic                s2_last;
  logic [IDX_W-1:0]    s2_index;
  logic [2*DATA_W:0]   s2_sum;
  logic                pipe_busy;

  logic [2*DATA_W:0]   run_max;
  logic [IDX_W-1:0]    run_idx;
  logic [2*DATA_W:0]   cand_max;
  logic [IDX_W-1:0]    cand_idx;
  logic                upd;
  logic                pub;

  mag_sq_pipe #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (reset_max),
    .in_valid  (bin_valid),
    .in_index  (bin_index),
    .in_re     (bin_re),
    .in_im     (bin_im),
    .out_valid (s2_valid),
    .out_last  (s2_last),
    .out_index (s2_index),
    .out_sum   (s2_sum),
    .pipe_busy (pipe_busy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Strict greater-than keeps the earliest (lowest) index on ties; the last
  // bin's own compare result feeds the publish directly through cand_*.
  always_comb begin
    upd        = 1'b0;
    cand_max   = run_max;
    cand_idx   = run_idx;
    pub        = s2_valid && s2_last && !reset_max;
    next_state = state;
    if (s2_valid && (s2_index >= LO_IDX) && (s2_index <= HI_IDX) && (s2_sum > run_max)) begin
      upd = 1'b1;
    end
    if (upd) begin
      cand_max = s2_sum;
      cand_idx = s2_index;
    end
    case (state)
      IDLE:    if (bin_valid || pipe_busy) next_state = ACCUM;
      ACCUM:   next_state = ACCUM;
      PUBLISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (pub) begin
      next_state = PUBLISH;
    end
    if (reset_max) begin
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_max    <= '0;
      run_idx    <= '0;
      peak_mag   <= '0;
      peak_index <= '0;
`ifdef PEAK_THRESH_EN
      peak_hit   <= 1'b0;
`endif
    end else if (reset_max) begin
      run_max <= '0;
      run_idx <= '0;
    end else if (pub) begin
      run_max <= '0;
      run_idx <= '0;
`ifdef PEAK_THRESH_EN
      if (cand_max >= thresh) begin
        peak_mag   <= cand_max;
        peak_index <= cand_idx;
        peak_hit   <= 1'b1;
      end else begin
        peak_mag   <= '0;
        peak_index <= '0;
        peak_hit   <= 1'b0;
      end
`else
      peak_mag   <= cand_max;
      peak_index <= cand_idx;
`endif
    end else begin
      run_max <= cand_max;
      run_idx <= cand_idx;
    end
  end

  assign frame_done = (state == PUBLISH);
  assign busy       = (state == ACCUM) || pipe_busy;

endmodule

// File: doc/fft_peak_tracker.md
Name: fft_peak_tracker

Overview:
- Consumer of the FFT output stream that the sampler control FSM drives during its output phase. It is the receiving end of that FSM's bin index, count-enable and max-reset signals.
- Squares and sums each complex bin into a magnitude, tracks the largest magnitude and its index over one frame, and publishes the result at frame end.
- Its output feeds the note/display logic downstream.

Parameters:
- DATA_W, 16, signed width of FFT real/imag outputs
- IDX_W, 9, bin index width (512-point frame)
- LO_BIN, 1, first bin eligible for peak (skips DC)
- HI_BIN, 255, last bin eligible for peak (first half of spectrum only)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- reset_max  in  1  sync clear of running max; held high by control while listening
- bin_valid  in  1  current bin_re/bin_im/bin_index valid (control output-count enable)
- bin_index  in  IDX_W  index of current bin (control output_index)
- bin_re  in  DATA_W  signed real part
- bin_im  in  DATA_W  signed imaginary part
- peak_index  out  IDX_W  index of frame maximum, held until next frame_done
- peak_mag  out  2*DATA_W+1  magnitude-squared of frame maximum, held
- frame_done  out  1  one-cycle pulse when peak_index/peak_mag update
- busy  out  1  high while a frame is being accumulated or pipeline is non-empty

Behaviour:
- Reset (reset_n low, async): every output is 0; running max, running index and pipeline valids are 0; FSM goes to IDLE.
- Pipeline, 2 stages:
  - S1 registers re*re and im*im (each 2*DATA_W bits, unsigned), plus index and valid.
  - S2 registers the sum (2*DATA_W+1 bits, no overflow possible), plus index, valid and a last flag.
  - The compare/update happens on the edge after S2. Total latency from the last bin to frame_done is 3 cycles.
- Eligibility: an S2 entry updates the max only if valid, LO_BIN <= index <= HI_BIN, and sum > run_max (strict). On ties the lower index wins.
- Last bin: the S1 input with bin_valid=1 and bin_index = all ones is tagged last.
- FSM states:
  - IDLE: waits for bin_valid=1, then goes to ACCUM and busy=1.
  - ACCUM: on last reaching the compare stage, goes to PUBLISH.
  - PUBLISH (one cycle): copies the final max into peak_index/peak_mag (including the last bin's own compare result), pulses frame_done, clears run_max and run_idx, then returns to IDLE.
- reset_max=1:
  - Clears run_max/run_idx and flushes pipeline valids that cycle.
  - Forces the FSM to IDLE from any state. No frame_done is produced for an aborted frame.
  - Does not alter peak_index/peak_mag.
  - If reset_max and bin_valid are high together, reset_max wins and the bin is dropped.
- bin_valid gaps mid-frame are tolerated (bubbles propagate through the pipeline). An index that does not increment is still compared normally.
- Frame with no eligible bin, or all eligible bins zero: publishes peak_mag=0, peak_index=0.
- Back-to-back frames: a new bin_valid may arrive the cycle after the last bin. It enters S1 while PUBLISH runs and starts the next ACCUM without loss.
- Async reset mid-frame: all state is lost and outputs are zero; no partial result is published.

Optional Feature:
- Macro PEAK_THRESH_EN.
- When defined:
  - Adds input thresh (2*DATA_W+1 bits).
  - In PUBLISH, if the final max < thresh, peak_index/peak_mag are loaded with 0 and frame_done still pulses.
  - Adds output peak_hit: set to (max >= thresh) in PUBLISH, held between publishes, 0 on reset.
- When undefined: no thresh port and no peak_hit port; every frame publishes its raw max.

Decomposition:
- Package fft_pkg holds:
  - constants FFT_N=512, IDX_W=9, DATA_W=16;
  - typedef mag_t (logic [2*DATA_W:0]);
  - typedef bin_idx_t;
  - FSM enum peak_state_t {IDLE, ACCUM, PUBLISH}.
- One sub-module, mag_sq_pipe: the two-stage square/sum pipeline, carrying valid, index and last sideband. The top level holds the FSM, compare and output registers.

Test Plan:
- Single bin: all bins zero except bin 37 with re=3, im=-4 -> frame_done 3 cycles after index 511, peak_index=37, peak_mag=25.
- Tie and eligibility: bins 10 and 20 both re=100, im=0; bin 0 re=1000; bin 300 re=2000 -> peak_index=10, peak_mag=10000.
- Last-bin max with range widened: HI_BIN=511, bin 511 re=-32768, im=-32768 -> peak_mag=2147483648, peak_index=511 (no overflow).
- Abort: reset_max asserted at bin 200 -> no frame_done; previous peak outputs unchanged. A following full frame publishes correctly.
- Back-to-back frames with a 5-cycle bin_valid gap inserted mid-frame -> two frame_done pulses, each carrying its own frame's max. busy is low only between frames.
- PEAK_THRESH_EN: thresh=26, max=25 -> peak_mag=0, peak_hit=0. thresh=25 -> peak_mag=25, peak_hit=1. reset_n low mid-frame -> all outputs 0 asynchronously.
